// File: rtl/thr_bank_ctrl.sv
// Double-buffered per-channel threshold lookup for the spike detector; 1-cycle registered lookup,
// no backpressure. Host writes land in the shadow bank; banks swap only on a chNo=0 sample.
module thr_bank_ctrl #(
   parameter int          NCH         = 160,
   parameter int          CHW         = 12,
   parameter logic [31:0] THR_DEFAULT = 32'hFFFFFF00,
   parameter logic [31:0] THR_OOR     = 32'h80000000
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           mua_valid,
   input  logic [31:0]    frameNo_in,
   input  logic [CHW-1:0] chNo_in,
   input  logic [31:0]    ch_hash_in,
   input  logic [31:0]    mua_data,
   input  logic           cfg_wr_en,
   input  logic [CHW-1:0] cfg_ch,
   input  logic [31:0]    cfg_thr,
   input  logic           cfg_commit,
   output logic           cfg_ready,
   output logic           commit_pending,
   output logic           bank_sel,
   output logic           out_valid,
   output logic [31:0]    out_frameNo,
   output logic [CHW-1:0] out_chNo,
   output logic [31:0]    out_ch_hash,
   output logic [31:0]    out_thr,
   output logic [31:0]    out_mua
);

   localparam int             AW    = $clog2(NCH);
   localparam logic [CHW-1:0] NCH_C = CHW'(NCH);
   localparam logic [AW-1:0]  LAST  = AW'(NCH - 1);

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_PENDING, S_COPY} state_t;

   state_t         state_q, state_d;
   logic [AW-1:0]  idx_q, idx_d;
   logic           bank_sel_q, bank_sel_d;
   logic [31:0]    bank0_q [NCH];
   logic [31:0]    bank1_q [NCH];

   logic           init_we, sh_we;
   logic [AW-1:0]  sh_idx;
   logic [31:0]    sh_dat, copy_dat, lk_dat, out_thr_d;
   logic           lk_oor;
   logic [AW-1:0]  lk_idx;

   logic           out_valid_q;
   logic [31:0]    out_frameNo_q, out_ch_hash_q, out_thr_q, out_mua_q;
   logic [CHW-1:0] out_chNo_q;

   // bank_sel_d already reflects a swap taken this cycle, so the swapping sample sees the new bank
   assign lk_oor   = (chNo_in >= NCH_C);
   assign lk_idx   = chNo_in[AW-1:0];
   assign lk_dat   = bank_sel_d ? bank1_q[lk_idx] : bank0_q[lk_idx];
   assign copy_dat = bank_sel_q ? bank1_q[idx_q] : bank0_q[idx_q];

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      bank_sel_d = bank_sel_q;
      init_we    = 1'b0;
      sh_we      = 1'b0;
      sh_idx     = idx_q;
      sh_dat     = copy_dat;
      case (state_q)
         S_INIT: begin
            init_we = 1'b1;
            idx_d   = idx_q + AW'(1);
            if (idx_q == LAST) begin
               idx_d   = '0;
               state_d = S_IDLE;
            end
         end
         S_IDLE: begin
            if (cfg_wr_en && (cfg_ch < NCH_C)) begin
               sh_we  = 1'b1;
               sh_idx = cfg_ch[AW-1:0];
               sh_dat = cfg_thr;
            end
            if (cfg_commit) state_d = S_PENDING;
         end
         S_PENDING: begin
            if (mua_valid && (chNo_in == '0)) begin
               bank_sel_d = ~bank_sel_q;
               idx_d      = '0;
               state_d    = S_COPY;
            end
         end
         S_COPY: begin
            sh_we = 1'b1;
            idx_d = idx_q + AW'(1);
            if (idx_q == LAST) begin
               idx_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_INIT;
         idx_q      <= '0;
         bank_sel_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         bank_sel_q <= bank_sel_d;
      end
   end

   // Shadow is the bank not selected; INIT is the only time the active bank is written
   always_ff @(posedge clk) begin
      if (init_we) begin
         bank0_q[idx_q] <= THR_DEFAULT;
         bank1_q[idx_q] <= THR_DEFAULT;
      end else if (sh_we) begin
         if (bank_sel_q) bank0_q[sh_idx] <= sh_dat;
         else            bank1_q[sh_idx] <= sh_dat;
      end
   end

   always_comb begin
      out_thr_d = lk_dat;
      if (lk_oor)                 out_thr_d = THR_OOR;
      else if (state_q == S_INIT) out_thr_d = THR_DEFAULT;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q   <= 1'b0;
         out_frameNo_q <= '0;
         out_chNo_q    <= '0;
         out_ch_hash_q <= '0;
         out_thr_q     <= '0;
         out_mua_q     <= '0;
      end else begin
         out_valid_q   <= mua_valid;
         out_frameNo_q <= frameNo_in;
         out_chNo_q    <= chNo_in;
         out_ch_hash_q <= ch_hash_in;
         out_thr_q     <= out_thr_d;
         out_mua_q     <= mua_data;
      end
   end

   assign cfg_ready      = (state_q == S_IDLE);
   assign commit_pending = (state_q == S_PENDING);
   assign bank_sel       = bank_sel_q;
   assign out_valid      = out_valid_q;
   assign out_frameNo    = out_frameNo_q;
   assign out_chNo       = out_chNo_q;
   assign out_ch_hash    = out_ch_hash_q;
   assign out_thr        = out_thr_q;
   assign out_mua        = out_mua_q;

endmodule

// File: tb/tb_thr_bank_ctrl.sv
// Directed bench for thr_bank_ctrl: init defaults, shadow writes, frame-aligned swap, copy-back,
// out-of-range channels and reset during a pending commit.
module tb_thr_bank_ctrl;

   localparam int NCH = 160;
   localparam int CHW = 12;
   localparam logic [31:0] DEF = 32'hFFFFFF00;
   localparam logic [31:0] OOR = 32'h80000000;
   localparam logic [31:0] T5  = 32'hFFFFF000;
   localparam logic [31:0] T0  = 32'h00000123;

   logic           clk = 1'b0;
   logic           rst;
   logic           mua_valid;
   logic [31:0]    frameNo_in;
   logic [CHW-1:0] chNo_in;
   logic [31:0]    ch_hash_in;
   logic [31:0]    mua_data;
   logic           cfg_wr_en;
   logic [CHW-1:0] cfg_ch;
   logic [31:0]    cfg_thr;
   logic           cfg_commit;
   logic           cfg_ready;
   logic           commit_pending;
   logic           bank_sel;
   logic           out_valid;
   logic [31:0]    out_frameNo;
   logic [CHW-1:0] out_chNo;
   logic [31:0]    out_ch_hash;
   logic [31:0]    out_thr;
   logic [31:0]    out_mua;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   thr_bank_ctrl #(.NCH(NCH), .CHW(CHW)) dut (
      .clk(clk), .rst(rst),
      .mua_valid(mua_valid), .frameNo_in(frameNo_in), .chNo_in(chNo_in),
      .ch_hash_in(ch_hash_in), .mua_data(mua_data),
      .cfg_wr_en(cfg_wr_en), .cfg_ch(cfg_ch), .cfg_thr(cfg_thr), .cfg_commit(cfg_commit),
      .cfg_ready(cfg_ready), .commit_pending(commit_pending), .bank_sel(bank_sel),
      .out_valid(out_valid), .out_frameNo(out_frameNo), .out_chNo(out_chNo),
      .out_ch_hash(out_ch_hash), .out_thr(out_thr), .out_mua(out_mua)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] fr, input logic [CHW-1:0] ch,
                        input logic [31:0] d);
      mua_valid  = v;
      frameNo_in = fr;
      chNo_in    = ch;
      ch_hash_in = {20'h0, ch} ^ 32'hC0DE0000;
      mua_data   = d;
   endtask

   initial begin
      rst = 1'b1;
      cfg_wr_en = 1'b0; cfg_ch = '0; cfg_thr = '0; cfg_commit = 1'b0;
      drive(1'b0, 32'd0, '0, 32'd0);
      step(); step();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_thr", out_thr, 32'd0);
      chk("rst_out_frame", out_frameNo, 32'd0);
      chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
      chk("rst_commit_pending", 32'(commit_pending), 32'd0);
      chk("rst_bank_sel", 32'(bank_sel), 32'd0);

      // INIT: NCH cycles after release; samples get the default threshold
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'd1, CHW'(i), 32'h100 + 32'(i));
         step();
         chk("init_valid", 32'(out_valid), 32'd1);
         chk("init_thr", out_thr, DEF);
         chk("init_chNo", 32'(out_chNo), 32'(i));
         chk("init_mua", out_mua, 32'h100 + 32'(i));
      end
      chk("init_hash", out_ch_hash, 32'hC0DE0003);
      drive(1'b0, 32'd1, '0, 32'd0);
      repeat (NCH - 5) step();
      chk("init_ready_low", 32'(cfg_ready), 32'd0);
      chk("init_invalid", 32'(out_valid), 32'd0);
      step();
      chk("init_ready_rise", 32'(cfg_ready), 32'd1);

      // IDLE: shadow writes do not affect lookups
      cfg_wr_en = 1'b1; cfg_ch = CHW'(0); cfg_thr = T0;
      step();
      cfg_ch = CHW'(5); cfg_thr = T5;
      step();
      cfg_wr_en = 1'b0;
      drive(1'b1, 32'd7, CHW'(5), 32'h55);
      step();
      chk("idle_ch5_old", out_thr, DEF);
      chk("idle_bank_sel", 32'(bank_sel), 32'd0);
      chk("idle_frame", out_frameNo, 32'd7);

      // Commit mid-frame; swap only on a valid chNo=0 sample
      drive(1'b1, 32'd7, CHW'(37), 32'h56);
      cfg_commit = 1'b1;
      step();
      cfg_commit = 1'b0;
      chk("pend_set", 32'(commit_pending), 32'd1);
      chk("pend_ready", 32'(cfg_ready), 32'd0);
      chk("pend_chNo", 32'(out_chNo), 32'd37);
      drive(1'b1, 32'd7, CHW'(5), 32'h57);
      step();
      chk("pend_ch5_old", out_thr, DEF);
      drive(1'b0, 32'd7, CHW'(0), 32'h58);
      step();
      chk("pend_no_swap_invalid", 32'(commit_pending), 32'd1);
      chk("pend_invalid_out", 32'(out_valid), 32'd0);
      drive(1'b1, 32'd8, CHW'(0), 32'h59);
      step();
      chk("swap_ch0_new", out_thr, T0);
      chk("swap_bank_sel", 32'(bank_sel), 32'd1);
      chk("swap_pending_clr", 32'(commit_pending), 32'd0);
      chk("swap_ready_low", 32'(cfg_ready), 32'd0);
      drive(1'b1, 32'd8, CHW'(5), 32'h5A);
      step();
      chk("swap_ch5_new", out_thr, T5);

      // COPY window: a write late in the window must be dropped
      drive(1'b0, 32'd8, '0, 32'd0);
      repeat (NCH - 3) step();
      cfg_wr_en = 1'b1; cfg_ch = CHW'(9); cfg_thr = 32'h77;
      step();
      cfg_wr_en = 1'b0;
      chk("copy_ready_low", 32'(cfg_ready), 32'd0);
      step();
      chk("copy_ready_rise", 32'(cfg_ready), 32'd1);

      // Commit with no writes: new active bank is the copied one
      cfg_commit = 1'b1;
      step();
      cfg_commit = 1'b0;
      drive(1'b1, 32'd9, CHW'(0), 32'h60);
      step();
      chk("copy_bank_sel", 32'(bank_sel), 32'd0);
      chk("copy_ch0", out_thr, T0);
      drive(1'b1, 32'd9, CHW'(5), 32'h61);
      step();
      chk("copy_ch5", out_thr, T5);
      drive(1'b1, 32'd9, CHW'(9), 32'h62);
      step();
      chk("copy_ch9_dropped", out_thr, DEF);
      drive(1'b1, 32'd9, CHW'(200), 32'h63);
      step();
      chk("oor_thr", out_thr, OOR);
      drive(1'b0, 32'd9, '0, 32'd0);
      repeat (NCH - 4) step();
      chk("copy2_ready_low", 32'(cfg_ready), 32'd0);
      step();
      chk("copy2_ready_rise", 32'(cfg_ready), 32'd1);

      // Out-of-range host writes (200, and 261 which aliases ch5 in low bits)
      cfg_wr_en = 1'b1; cfg_ch = CHW'(200); cfg_thr = 32'h55;
      step();
      cfg_ch = CHW'(261);
      step();
      cfg_wr_en = 1'b0;
      cfg_commit = 1'b1;
      step();
      cfg_commit = 1'b0;
      drive(1'b1, 32'd10, CHW'(0), 32'h70);
      step();
      chk("oorw_bank_sel", 32'(bank_sel), 32'd1);
      drive(1'b1, 32'd10, CHW'(5), 32'h71);
      step();
      chk("oorw_ch5", out_thr, T5);
      drive(1'b1, 32'd10, CHW'(200), 32'h72);
      step();
      chk("oorw_ch200", out_thr, OOR);
      drive(1'b0, 32'd10, '0, 32'd0);
      repeat (NCH - 2) step();
      chk("copy3_ready", 32'(cfg_ready), 32'd1);

      // Reset while a commit is pending
      cfg_commit = 1'b1;
      step();
      cfg_commit = 1'b0;
      chk("pend2_set", 32'(commit_pending), 32'd1);
      chk("pend2_bank_sel", 32'(bank_sel), 32'd1);
      rst = 1'b1;
      step();
      chk("rst2_pending", 32'(commit_pending), 32'd0);
      chk("rst2_bank_sel", 32'(bank_sel), 32'd0);
      chk("rst2_ready", 32'(cfg_ready), 32'd0);
      chk("rst2_out_valid", 32'(out_valid), 32'd0);
      rst = 1'b0;
      drive(1'b1, 32'd11, CHW'(5), 32'h80);
      step();
      chk("rst2_init_ch5", out_thr, DEF);
      chk("rst2_init_ready", 32'(cfg_ready), 32'd0);
      drive(1'b0, 32'd11, '0, 32'd0);
      repeat (NCH - 1) step();
      chk("rst2_ready_rise", 32'(cfg_ready), 32'd1);
      drive(1'b1, 32'd12, CHW'(5), 32'h81);
      step();
      chk("rst2_ch5_default", out_thr, DEF);
      drive(1'b1, 32'd12, CHW'(0), 32'h82);
      step();
      chk("rst2_ch0_default", out_thr, DEF);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
